// File: rtl/axi4l_gpio_slv.sv
// AXI4-Lite slave with GPIO_IN (0x0, RO), reserved (0x4), GPIO_OUT (0x8, RW) and ID (0xC, RO).
// Optional macro GPIO_IN_SYNC_EN adds a 2-flop synchroniser on gpio_in.
module axi4l_gpio_slv #(
  parameter int          ADDR_W  = 4,
  parameter logic [31:0] OUT_RST = 32'h0000_0000,
  parameter logic [31:0] ID_VAL  = 32'h4750_494F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {REG_IN = 2'd0, REG_RSVD = 2'd1, REG_OUT = 2'd2, REG_ID = 2'd3} reg_sel_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> 4) == '0;
  endfunction

  logic              ready_en_q;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       gpio_out_q, gpio_out_d;
  logic [31:0]       gpio_in_s;

`ifdef GPIO_IN_SYNC_EN
  logic [31:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end
  assign gpio_in_s = sync2_q;
`else
  assign gpio_in_s = gpio_in;
`endif

  // Readies are held low in reset and until the first edge after release.
  assign s_awready = ready_en_q & ~aw_got_q & ~bvalid_q;
  assign s_wready  = ready_en_q & ~w_got_q & ~bvalid_q;
  assign s_arready = ready_en_q & ~rvalid_q;

  logic              aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign ar_hs   = s_arvalid & s_arready;
  assign wr_fire = (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign wr_addr = aw_got_q ? awaddr_q : s_awaddr;
  assign wr_data = w_got_q ? wdata_q : s_wdata;
  assign wr_strb = w_got_q ? wstrb_q : s_wstrb;

  // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    gpio_out_d = gpio_out_q;
    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = s_awaddr;
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end
    if (wr_fire) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      if (in_range(wr_addr) && reg_sel_e'(wr_addr[3:2]) == REG_OUT) begin
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) gpio_out_d[8*i +: 8] = wr_data[8*i +: 8];
      end
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      if (!in_range(s_araddr)) begin
        rresp_d = RESP_SLVERR;
      end else begin
        unique case (reg_sel_e'(s_araddr[3:2]))
          REG_IN:   rdata_d = gpio_in_s;
          REG_RSVD: rdata_d = '0;
          REG_OUT:  rdata_d = gpio_out_q;
          REG_ID:   rdata_d = ID_VAL;
        endcase
      end
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      gpio_out_q <= OUT_RST;
    end else begin
      ready_en_q <= 1'b1;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      gpio_out_q <= gpio_out_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_axi4l_gpio_slv.sv
// Self-checking bench for axi4l_gpio_slv: directed vector table, hand-written corner
// sequences and a randomized pass against a register-map model.
module tb_axi4l_gpio_slv;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] ID_VAL = 32'h4750_494F;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]       s_wdata, s_rdata, gpio_in, gpio_out;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  axi4l_gpio_slv #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] out_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-map model: word offset selects the register, only 0x8 is writable.
  function automatic logic [31:0] model_rd(input logic [3:0] a, input logic [31:0] pins);
    case (a[3:2])
      2'd0:    return pins;
      2'd2:    return out_m;
      2'd3:    return ID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] r = out_m;
    if (a[3:2] == 2'd2)
      for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    logic [1:0] r0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    while (!(aw_done && w_done) && t < 50) begin
      s_awvalid = !aw_done && t >= aw_dly;
      s_wvalid  = !w_done && t >= w_dly;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (aw_done != w_done) check("half_captured_ready_low", aw_done ? s_awready : s_wready, 1'b0);
      t++;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) check("write_handshake_timeout", 32'd0, 32'd1);
    check("bvalid_after_later_hs", s_bvalid, 1'b1);
    r0 = s_bresp;
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_held", s_bvalid, 1'b1);
      check("bresp_stable", s_bresp, r0);
      check("no_second_write", {s_awready, s_wready}, 2'b00);
    end
    resp = s_bresp;
    s_bready = 1;
    tick();
    s_bready = 0;
    check("bvalid_drop", s_bvalid, 1'b0);
    check("write_readies_back", {s_awready, s_wready}, 2'b11);
  endtask

  task automatic do_read(input logic [3:0] a, input int r_dly, output logic [31:0] data, output logic [1:0] resp);
    bit hs = 0, h;
    int t = 0;
    s_araddr = a;
    s_arvalid = 1;
    while (!hs && t < 50) begin
      h = s_arready;
      tick();
      hs = h;
      t++;
    end
    s_arvalid = 0;
    if (!hs) check("read_handshake_timeout", 32'd0, 32'd1);
    check("rvalid_1cyc", s_rvalid, 1'b1);
    data = s_rdata; resp = s_rresp;
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_held", s_rvalid, 1'b1);
      check("rdata_stable", s_rdata, data);
      check("arready_low", s_arready, 1'b0);
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    check("rvalid_drop", s_rvalid, 1'b0);
    check("arready_back", s_arready, 1'b1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d, old_pins;
    logic [1:0]  r;

    vecs[0]  = '{1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'h8, 32'h1122_3344, 4'b0101, 0, 0, 0, 32'h0, 2'b00, 32'hDE22_BE44};
    vecs[3]  = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 1, 32'hDE22_BE44, 2'b00, 32'hDE22_BE44};
    vecs[4]  = '{1'b1, 4'h8, 32'hCAFE_F00D, 4'hF, 3, 0, 4, 32'h0, 2'b00, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 4, ID_VAL, 2'b00, 32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'h0, 2'b00, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 4'hC, 32'h0, 4'hF, 1, 1, 0, 32'h0, 2'b00, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 32'h1234_ABCD, 2'b00, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 4'h6, 32'h0, 4'hF, 0, 0, 0, 32'h0, 2'b00, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 4'hA, 32'h0, 4'b1000, 0, 0, 0, 32'h0, 2'b00, 32'h00FE_F00D};
    vecs[12] = '{1'b1, 4'h8, 32'h1234_5678, 4'b0011, 0, 2, 2, 32'h0, 2'b00, 32'h00FE_5678};
    vecs[13] = '{1'b0, 4'hB, 32'h0, 4'h0, 0, 0, 0, 32'h00FE_5678, 2'b00, 32'h00FE_5678};

    rst = 1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0; gpio_in = 32'h1234_ABCD;
    out_m = 32'h0;
    tick();
    check("rst_readies_low", {s_awready, s_wready, s_arready}, 3'b000);
    check("rst_valids_low", {s_bvalid, s_rvalid}, 2'b00);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_resps", {s_bresp, s_rresp}, 4'h0);
    rst = 0;
    tick();
    check("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].hold, r);
        check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].addr, vecs[i].hold, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
      end
      check($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_gpio);
    end
    out_m = 32'h00FE_5678;

    // Same-cycle read and write of GPIO_OUT: read returns the pre-write value.
    s_awaddr = 4'h8; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF; s_araddr = 4'h8;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("rw_same_rdata_old", s_rdata, out_m);
    check("rw_same_valids", {s_bvalid, s_rvalid}, 2'b11);
    check("rw_same_gpio_new", gpio_out, 32'hA5A5_A5A5);
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    check("rw_same_done", {s_bvalid, s_rvalid}, 2'b00);
    out_m = 32'hA5A5_A5A5;

    // GPIO_IN latency relative to pin changes.
    gpio_in = 32'h0F0F_0F0F;
    repeat (3) tick();
    old_pins = gpio_in;
    gpio_in = 32'h7777_1111;
`ifdef GPIO_IN_SYNC_EN
    do_read(4'h0, 0, d, r);
    check("sync_old_value", d, old_pins);
    repeat (2) tick();
    do_read(4'h0, 0, d, r);
    check("sync_new_value", d, 32'h7777_1111);
`else
    do_read(4'h0, 0, d, r);
    check("comb_new_value", d, 32'h7777_1111);
    check("comb_not_old", d == old_pins, 1'b0);
`endif

    // Randomized traffic against the register-map model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  a  = 4'($urandom_range(0, 15));
      logic [31:0] wd = $urandom;
      logic [3:0]  st = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
        out_m = model_wr(a, wd, st);
        check($sformatf("rnd%0d_bresp", n), r, 2'b00);
      end else begin
        gpio_in = $urandom;
        repeat (2) tick();
        do_read(a, $urandom_range(0, 2), d, r);
        check($sformatf("rnd%0d_rdata", n), d, model_rd(a, gpio_in));
        check($sformatf("rnd%0d_rresp", n), r, 2'b00);
      end
      check($sformatf("rnd%0d_gpio_out", n), gpio_out, out_m);
    end

    // Make GPIO_OUT non-reset, then reset mid-transaction with W captured and R pending.
    do_write(4'h8, 32'h5555_AAAA, 4'hF, 0, 0, 0, r);
    s_wdata = 32'hBAD0_BAD0; s_wstrb = 4'hF; s_wvalid = 1;
    s_araddr = 4'hC; s_arvalid = 1;
    tick();
    s_wvalid = 0; s_arvalid = 0;
    #2 rst = 1;
    #1;
    check("midrst_gpio_out", gpio_out, 32'h0);
    check("midrst_valids", {s_bvalid, s_rvalid}, 2'b00);
    check("midrst_readies", {s_awready, s_wready, s_arready}, 3'b000);
    tick();
    rst = 0;
    tick();
    check("midrst_release_readies", {s_awready, s_wready, s_arready}, 3'b111);
    do_write(4'h8, 32'h0000_C3C3, 4'hF, 2, 0, 0, r);
    check("midrst_fresh_write", gpio_out, 32'h0000_C3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
